alu_op_decoder: RTL and testbench
=================================

// Module: alu_op_decoder
// PURPOSE
//  Registered decode stage that produces the 4-bit ALU operation code plus operand selects and immediate for the ALU.
//  It is the encoding end of the ALU control interface.
//  Accepts a fetched RV32I instruction over valid/ready and presents one decoded bundle one cycle later.
//  Sits between fetch and execute. Supports stall (backpressure) and flush.
// PARAMETERS
//  XLEN      32  data/PC width
//  CNT_W     16  width of saturating illegal-instruction counter
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      synchronous, active-high
//  in_valid     in   1      instruction/pc valid from fetch
//  in_ready     out  1      decoder can accept this cycle
//  in_instr     in   32     raw instruction
//  in_pc        in   XLEN   instruction address
//  flush        in   1      kill held and incoming instruction
//  out_valid    out  1      decoded bundle valid
//  out_ready    in   1      execute accepts bundle
//  alu_ctrl     out  4      0 ADD,1 SUB,2 SLL,3 SRA,4 SRL,5 OR,6 XOR,7 SLT,8 SLTU,9 AND
//  a_sel        out  2      0 rs1, 1 pc, 2 zero
//  b_sel        out  1      0 rs2, 1 imm
//  imm          out  XLEN   sign-extended immediate (I/S/B/U/J per opcode)
//  rs1,rs2,rd   out  5 ea   register indices
//  reg_write    out  1      writes rd (forced 0 when rd==0)
//  out_pc       out  XLEN   registered pc
//  illegal      out  1      bundle holds an undecodable instruction
//  illegal_cnt  out  CNT_W  saturating count of illegal bundles accepted by execute
// BEHAVIOUR
//  Reset: out_valid=0, illegal=0, illegal_cnt=0, all bundle fields 0 (alu_ctrl=ADD).
//  Single-entry output register. in_ready = !out_valid || out_ready (combinational).
//  Load when in_valid && in_ready && !flush. Bundle appears the next cycle (latency 1).
//  out_valid clears when out_ready && !load.
//  Held bundle is stable while out_valid && !out_ready.
//  Flush has priority over everything except reset:
//   - next cycle out_valid=0.
//   - the in-cycle instruction is dropped, but in_ready still follows the rule above.
//   - no illegal_cnt update.
//  Decode rules:
//   - OP 0110011: f3/f7 map to ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
//     Only f7 values 0000000 and 0100000 are accepted; 0100000 is allowed only with f3 000 or 101.
//   - OP-IMM 0010011: same map, b_sel=1. SLLI needs f7=0; SRLI/SRAI need f7 0000000/0100000.
//   - LUI: ADD, a_sel=zero, b_sel=imm. AUIPC: ADD, a_sel=pc, b_sel=imm.
//   - LOAD/STORE: ADD rs1+imm. STORE and BRANCH have reg_write=0.
//   - JAL: ADD pc+imm. JALR: ADD rs1+imm, f3 must be 000. Both have reg_write=1.
//   - BRANCH: BEQ/BNE->SUB, BLT/BGE->SLT, BLTU/BGEU->SLTU, b_sel=rs2. f3 010/011 are illegal.
//  Illegal: any other opcode or rejected funct. Output bundle is alu_ctrl=ADD, reg_write=0, illegal=1.
//  Low two bits != 11 is also illegal.
//  illegal_cnt increments on the out_valid && out_ready && illegal handshake.
//  It saturates at 2^CNT_W-1, and wraps never.
//  Reset mid-stall drops the held bundle; in_ready=1 in the first cycle after reset.
// STRUCTURE
//  Package alu_pkg:
//   - alu_op_e enum (4-bit codes above), a_sel_e, opcode localparams.
//   - funct7 constants F7_BASE and F7_ALT.
//  The ALU imports the same enum.
//  One sub-module, imm_gen: combinational immediate extraction by format.
//  The top holds the decode comb logic, the handshake, the output register and the counter.
// TESTING
//  1. reset, then 0x002081B3 (add x3,x1,x2) -> next cycle out_valid=1, alu_ctrl=0, rd=3, reg_write=1, b_sel=0.
//  2. 0x4020D193 (srai x3,x1,2) -> alu_ctrl=3, b_sel=1, imm=2. 0x0020D193 -> alu_ctrl=4.
//  3. 0xFE208EE3 (beq, negative offset) -> alu_ctrl=1, reg_write=0, imm=0xFFFFFFFC.
//  4. out_ready=0 for 3 cycles with in_valid=1:
//     - bundle held stable, in_ready=0, second instruction not lost.
//     - order preserved after out_ready=1.
//  5. 0xFFFFFFFF, 0x0020C1B3 with f7=0x01 (0x0220C1B3) -> illegal=1, alu_ctrl=0, reg_write=0, illegal_cnt=2.
//     Counter forced near max -> saturates.
//  6. flush while out_valid && !out_ready -> out_valid=0 next cycle, illegal_cnt unchanged.
//     Reset during stall -> all outputs return to reset values.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control encodings, RV32I opcode/funct constants and the base funct3 -> ALU op map.
// Imported by the decoder, the immediate generator and the ALU itself.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SRA  = 4'd3,
        ALU_SRL  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_SLT  = 4'd7,
        ALU_SLTU = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SHAMT
    } imm_fmt_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // funct3 map shared by OP and OP-IMM before the funct7 alternate (SUB/SRA) is applied.
    function automatic alu_op_e base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  base_alu = ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decoder_imm_gen.sv
// Immediate extraction by format, sign-extended to XLEN (XLEN >= 32); shift-immediates yield the zero-extended shamt.
// Purely combinational, no latency; no flow control.
// Backpressure: none, follows its inputs every cycle.
module imm_gen
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt)
            IMM_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:     imm32 = {instr[31:12], 12'h000};
            IMM_J:     imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_SHAMT: imm32 = {27'd0, instr[24:20]};
            default:   imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/alu_op_decoder.sv
// RV32I decode stage: ALU op, operand selects, immediate, register indices, illegal flag and saturating illegal count.
// Latency 1: an accepted instruction appears in the single-entry output register on the next cycle.
// Backpressure: in_ready = !out_valid || out_ready; the held bundle is frozen while stalled; flush kills held and incoming.
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_ctrl,
    output logic [1:0]       a_sel,
    output logic             b_sel,
    output logic [XLEN-1:0]  imm,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic             reg_write,
    output logic [XLEN-1:0]  out_pc,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        alu_op_e         alu;
        a_sel_e          a_sel;
        logic            b_sel;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } bundle_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            legal;
    imm_fmt_e        fmt;
    logic [XLEN-1:0] imm_w;
    bundle_t         dec_raw;
    bundle_t         dec;
    bundle_t         held;
    logic            load;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (fmt),
        .imm   (imm_w)
    );

    always_comb begin
        dec_raw       = '0;
        dec_raw.alu   = ALU_ADD;
        dec_raw.a_sel = A_RS1;
        dec_raw.rs1   = in_instr[19:15];
        dec_raw.rs2   = in_instr[24:20];
        dec_raw.rd    = in_instr[11:7];
        fmt           = IMM_NONE;
        legal         = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec_raw.alu       = base_alu(f3);
                dec_raw.reg_write = 1'b1;
                if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))
                    dec_raw.alu = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
                else if (f7 != F7_BASE)
                    legal = 1'b0;
            end
            OPC_OP_IMM: begin
                dec_raw.alu       = base_alu(f3);
                dec_raw.b_sel     = 1'b1;
                dec_raw.reg_write = 1'b1;
                fmt               = IMM_I;
                // Shift-immediates reuse imm[11:5] as funct7, so only the shamt is forwarded.
                if (f3 == 3'b001) begin
                    fmt   = IMM_SHAMT;
                    legal = (f7 == F7_BASE);
                end else if (f3 == 3'b101) begin
                    fmt   = IMM_SHAMT;
                    legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                    if (f7 == F7_ALT)
                        dec_raw.alu = ALU_SRA;
                end
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_raw.a_sel     = (opcode == OPC_LUI) ? A_ZERO : A_PC;
                dec_raw.b_sel     = 1'b1;
                dec_raw.reg_write = 1'b1;
                fmt               = IMM_U;
            end
            OPC_LOAD, OPC_JALR: begin
                dec_raw.b_sel     = 1'b1;
                dec_raw.reg_write = 1'b1;
                fmt               = IMM_I;
                if (opcode == OPC_JALR)
                    legal = (f3 == 3'b000);
            end
            OPC_STORE: begin
                dec_raw.b_sel = 1'b1;
                fmt           = IMM_S;
            end
            OPC_JAL: begin
                dec_raw.a_sel     = A_PC;
                dec_raw.b_sel     = 1'b1;
                dec_raw.reg_write = 1'b1;
                fmt               = IMM_J;
            end
            OPC_BRANCH: begin
                fmt = IMM_B;
                case (f3[2:1])
                    2'b00:   dec_raw.alu = ALU_SUB;
                    2'b10:   dec_raw.alu = ALU_SLT;
                    2'b11:   dec_raw.alu = ALU_SLTU;
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        dec           = dec_raw;
        dec.imm       = imm_w;
        dec.reg_write = dec_raw.reg_write && (in_instr[11:7] != 5'd0);
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        dec.pc = in_pc;
    end

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            held        <= '0;
            illegal_cnt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                held      <= dec;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready && held.illegal && illegal_cnt != CNT_MAX)
                illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    assign alu_ctrl  = held.alu;
    assign a_sel     = held.a_sel;
    assign b_sel     = held.b_sel;
    assign imm       = held.imm;
    assign rs1       = held.rs1;
    assign rs2       = held.rs2;
    assign rd        = held.rd;
    assign reg_write = held.reg_write;
    assign out_pc    = held.pc;
    assign illegal   = held.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Scoreboarded bench for alu_op_decoder: directed RV32I cases, stall/flush/reset scenarios, then random traffic.
module tb_alu_op_decoder;

    localparam int CW      = 4;
    localparam int CNT_TOP = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [31:0]   in_pc;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    alu_ctrl;
    logic [1:0]    a_sel;
    logic          b_sel;
    logic [31:0]   imm;
    logic [4:0]    rs1, rs2, rd;
    logic          reg_write;
    logic [31:0]   out_pc;
    logic          illegal;
    logic [CW-1:0] illegal_cnt;

    alu_op_decoder #(.XLEN(32), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alu_ctrl(alu_ctrl), .a_sel(a_sel), .b_sel(b_sel),
        .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write),
        .out_pc(out_pc), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  alu;
        logic [1:0]  asel;
        logic        bsel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    exp_t        pend_exp;
    bit          pend_push = 0;
    int unsigned cnt_model = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: RV32I semantics written directly from the instruction-set rules.
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        int   s;
        int   f3;
        int   f7;
        bit   ok;
        int   by_f3[8] = '{0, 2, 7, 8, 6, 4, 5, 9};
        s  = i;
        f3 = int'(i[14:12]);
        f7 = int'(i[31:25]);
        ok = 1;
        e  = '0;
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.rd  = i[11:7];
        case (i[6:0])
            7'h33: begin
                e.wr  = 1;
                e.alu = 4'(by_f3[f3]);
                if (f7 == 32 && f3 == 0) e.alu = 1;
                else if (f7 == 32 && f3 == 5) e.alu = 3;
                else if (f7 != 0) ok = 0;
            end
            7'h13: begin
                e.wr = 1; e.bsel = 1;
                e.alu = 4'(by_f3[f3]);
                e.imm = s >>> 20;
                if (f3 == 1) begin ok = (f7 == 0); e.imm = 32'(i[24:20]); end
                if (f3 == 5) begin
                    ok = (f7 == 0 || f7 == 32);
                    if (f7 == 32) e.alu = 3;
                    e.imm = 32'(i[24:20]);
                end
            end
            7'h37: begin e.wr = 1; e.asel = 2; e.bsel = 1; e.imm = i & 32'hFFFF_F000; end
            7'h17: begin e.wr = 1; e.asel = 1; e.bsel = 1; e.imm = i & 32'hFFFF_F000; end
            7'h03: begin e.wr = 1; e.bsel = 1; e.imm = s >>> 20; end
            7'h23: begin e.bsel = 1; e.imm = ((s >>> 25) << 5) | int'(i[11:7]); end
            7'h6F: begin
                e.wr = 1; e.asel = 1; e.bsel = 1;
                e.imm = ((s >>> 31) << 20) | (int'(i[19:12]) << 12) | (int'(i[20]) << 11) | (int'(i[30:21]) << 1);
            end
            7'h67: begin e.wr = 1; e.bsel = 1; e.imm = s >>> 20; ok = (f3 == 0); end
            7'h63: begin
                e.imm = ((s >>> 31) << 12) | (int'(i[7]) << 11) | (int'(i[30:25]) << 5) | (int'(i[11:8]) << 1);
                if (f3 < 2) e.alu = 1;
                else if (f3 == 4 || f3 == 5) e.alu = 7;
                else if (f3 >= 6) e.alu = 8;
                else ok = 0;
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            e = '0;
            e.ill = 1;
        end
        if (e.rd == 0) e.wr = 0;
        e.pc = pc;
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [6:0]  opcs[9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h63};
        int          k;
        r = $urandom;
        k = $urandom_range(0, 11);
        if (k < 9) begin
            r[6:0] = opcs[k];
            if ($urandom_range(0, 2) != 0)
                r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        end
        return r;
    endfunction

    // One cycle of stimulus, driven just after the rising edge.
    task automatic cycle(input bit iv, input logic [31:0] ins, input bit ordy, input bit fl, input bit rst);
        if (pend_push) q.push_back(pend_exp);
        pend_push = 0;
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc_ctr;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        if (!rst && !fl && iv && (q.size() == 0 || ordy)) begin
            pend_push = 1;
            pend_exp  = ref_decode(ins, pc_ctr);
        end
        pc_ctr += 4;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares mid-cycle, then retires the front entry according to the coming edge.
    initial begin
        exp_t act;
        bit   was_rst;
        was_rst = 0;
        forever begin
            @(negedge clk);
            act = '{alu: alu_ctrl, asel: a_sel, bsel: b_sel, imm: imm, rs1: rs1, rs2: rs2,
                    rd: rd, wr: reg_write, pc: out_pc, ill: illegal};
            if (was_rst) chk("reset_bundle", act, '0);
            chk("out_valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, (q.size() == 0) || out_ready);
            chk("illegal_cnt", illegal_cnt, cnt_model);
            if (q.size() != 0 && out_valid) chk("bundle", act, q[0]);
            if (reset) begin
                q.delete();
                cnt_model = 0;
            end else if (q.size() != 0 && (out_ready || flush)) begin
                if (out_ready && !flush && q[0].ill && cnt_model < CNT_TOP) cnt_model++;
                void'(q.pop_front());
            end
            was_rst = reset;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, compared=%0d", compared);
        $fatal(1);
    end

    initial begin
        logic [31:0] dir[4] = '{32'h002081B3, 32'h4020D193, 32'h0020D193, 32'hFE208EE3};
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 0, 1);
        foreach (dir[k]) cycle(1, dir[k], 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        // stall with a second instruction waiting; it must follow the first
        cycle(1, 32'h002081B3, 1, 0, 0);
        repeat (3) cycle(1, 32'h0020D193, 0, 0, 0);
        cycle(1, 32'h0020D193, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        // illegal opcode and rejected funct7
        cycle(1, 32'hFFFFFFFF, 1, 0, 0);
        cycle(1, 32'h0220C1B3, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        // flush of a stalled illegal bundle plus an incoming instruction
        cycle(1, 32'hFFFFFFFF, 1, 0, 0);
        cycle(1, 32'h002081B3, 0, 1, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        // reset during a stall
        cycle(1, 32'h002081B3, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        // drive the counter into saturation
        repeat (CNT_TOP + 5) cycle(1, 32'hFFFFFFFF, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        repeat (2000) begin
            cycle($urandom_range(0, 3) != 0, gen_instr(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 31) == 0, $urandom_range(0, 499) == 0);
        end
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
